// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI write engine.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND_ADDRESS,
        SEND_DATA,
        COMPLETE
    } spi_wr_state_t;

    // Wide enough for REG_WIDTH*(255+1) = 2048 total bits without wrapping.
    localparam int SPI_CNT_W = 12;

endpackage

// File: rtl/spi_piso_shift.sv
// Parallel-load, MSB-first shift register feeding MOSI; load wins over shift.
module spi_piso_shift #(
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [REG_WIDTH-1:0] data_i,
    output logic                 msb_o
);

    logic [REG_WIDTH-1:0] shreg_q;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {shreg_q[REG_WIDTH-2:0], 1'b0};
        end
    end

    assign msb_o = shreg_q[REG_WIDTH-1];

endmodule

// File: rtl/spi_write.sv
// SPI write engine: sends a start address then up to num_regs bytes pulled
// from an upstream FIFO, with gated SCLK and completion/underflow pulses.
module spi_write
    import spi_pkg::*;
#(
    parameter int REG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 new_command,
    input  logic                 is_write,
    input  logic [7:0]           num_regs_to_write,
    input  logic [REG_WIDTH-1:0] start_write_register_addr,
    input  logic [REG_WIDTH-1:0] fifo_rd_data,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    output logic                 serial_out,
    output logic                 spi_clk,
    output logic                 busy,
    output logic                 write_complete,
    output logic                 underflow_err
);

    localparam int IDX_W = $clog2(REG_WIDTH);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(REG_WIDTH - 1);

    spi_wr_state_t        state_q;
    logic                 prevCmd_q;
    logic                 sclkEn_q;
    logic                 busy_q;
    logic                 complete_q;
    logic                 underErr_q;
    logic                 underflow_q;
    logic [7:0]           numRegs_q;
    logic [7:0]           popCnt_q;
    logic [SPI_CNT_W-1:0] bitCnt_q;
    logic [IDX_W-1:0]     bitIdx_q;

    logic                 sending;
    logic                 accept;
    logic                 popDue;
    logic                 moreWords;
    logic [SPI_CNT_W-1:0] lastBit;
    logic                 pisoLoad;
    logic                 pisoShift;
    logic [REG_WIDTH-1:0] pisoData;
    logic                 pisoMsb;

    assign sending = (state_q == SEND_ADDRESS) || (state_q == SEND_DATA);
    assign accept  = new_command && !prevCmd_q && is_write &&
                     (state_q == IDLE) && (num_regs_to_write != 8'd0);
    assign lastBit = SPI_CNT_W'(REG_WIDTH * (int'(numRegs_q) + 1) - 1);

    // A pop is requested while bit 1 of the current word is on the wire, so the
    // FIFO word is valid during bit 0 and can be loaded at that word boundary.
    assign popDue     = sending && (bitIdx_q == IDX_W'(1)) &&
                        (popCnt_q != numRegs_q) && !underflow_q;
    assign fifo_rd_en = rstn && popDue && !fifo_empty;
    assign moreWords  = !underflow_q && (bitCnt_q != lastBit);

    assign pisoLoad  = accept || (sending && (bitIdx_q == '0) && moreWords);
    assign pisoData  = accept ? start_write_register_addr : fifo_rd_data;
    assign pisoShift = sending && !pisoLoad;

    spi_piso_shift #(
        .REG_WIDTH (REG_WIDTH)
    ) u_piso (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .load_i  (pisoLoad),
        .shift_i (pisoShift),
        .data_i  (pisoData),
        .msb_o   (pisoMsb)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            prevCmd_q   <= 1'b0;
            sclkEn_q    <= 1'b0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            underErr_q  <= 1'b0;
            underflow_q <= 1'b0;
            numRegs_q   <= '0;
            popCnt_q    <= '0;
            bitCnt_q    <= '0;
            bitIdx_q    <= '0;
        end else begin
            prevCmd_q  <= new_command;
            complete_q <= 1'b0;
            underErr_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= SEND_ADDRESS;
                        sclkEn_q    <= 1'b1;
                        busy_q      <= 1'b1;
                        numRegs_q   <= num_regs_to_write;
                        popCnt_q    <= '0;
                        bitCnt_q    <= '0;
                        bitIdx_q    <= IDX_TOP;
                        underflow_q <= 1'b0;
                    end
                end
                SEND_ADDRESS, SEND_DATA: begin
                    bitCnt_q <= bitCnt_q + SPI_CNT_W'(1);
                    if (fifo_rd_en) begin
                        popCnt_q <= popCnt_q + 8'd1;
                    end
                    if (popDue && fifo_empty) begin
                        underflow_q <= 1'b1;
                    end
                    if (bitIdx_q == '0) begin
                        bitIdx_q <= IDX_TOP;
                        if (moreWords) begin
                            state_q <= SEND_DATA;
                        end else begin
                            state_q    <= COMPLETE;
                            sclkEn_q   <= 1'b0;
                            complete_q <= 1'b1;
                            underErr_q <= underflow_q;
                        end
                    end else begin
                        bitIdx_q <= bitIdx_q - IDX_W'(1);
                    end
                end
                COMPLETE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // SCLK is high in the second half of each bit so the peripheral samples mid-bit.
    assign spi_clk        = rstn && sclkEn_q && !clk;
    assign serial_out     = sclkEn_q && pisoMsb;
    assign busy           = busy_q;
    assign write_complete = complete_q;
    assign underflow_err  = underErr_q;

endmodule

// File: tb/tb_spi_write.sv
// Randomized bench for spi_write: a FIFO model feeds bytes and every transfer is
// compared against the bit stream, pop count and pulses predicted from the command.
module tb_spi_write;

    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          new_command = 1'b0;
    logic          is_write = 1'b0;
    logic [7:0]    num_regs_to_write = '0;
    logic [RW-1:0] start_write_register_addr = '0;
    logic [RW-1:0] fifo_rd_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic          serial_out;
    logic          spi_clk;
    logic          busy;
    logic          write_complete;
    logic          underflow_err;

    int checks = 0;
    int failures = 0;

    int cycNum = 0;
    byte unsigned fifoQ[$];
    byte unsigned stimQ[$];
    int overPops = 0;

    int sclkEdges, firstEdgeCyc, lastEdgeCyc, popsSeen, wcCount, wcCyc;
    int ueAtWc, ueStray, busyDrop, busyCycles;
    logic mosiBits[$];

    spi_write #(.REG_WIDTH(RW)) dut (
        .clk                       (clk),
        .rstn                      (rstn),
        .new_command               (new_command),
        .is_write                  (is_write),
        .num_regs_to_write         (num_regs_to_write),
        .start_write_register_addr (start_write_register_addr),
        .fifo_rd_data              (fifo_rd_data),
        .fifo_empty                (fifo_empty),
        .fifo_rd_en                (fifo_rd_en),
        .serial_out                (serial_out),
        .spi_clk                   (spi_clk),
        .busy                      (busy),
        .write_complete            (write_complete),
        .underflow_err             (underflow_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycNum <= cycNum + 1;

    // Upstream FIFO with one-cycle read latency; a pop while empty is an error.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (fifoQ.size() > 0) fifo_rd_data <= fifoQ.pop_front();
            else overPops++;
        end
        fifo_empty <= (fifoQ.size() == 0);
    end

    always @(negedge clk) begin
        #1;
        if (spi_clk) begin
            if (sclkEdges == 0) firstEdgeCyc = cycNum;
            lastEdgeCyc = cycNum;
            sclkEdges++;
            mosiBits.push_back(serial_out);
            if (!busy) busyDrop++;
        end
        if (busy) busyCycles++;
        if (fifo_rd_en) popsSeen++;
        if (write_complete) begin
            wcCount++;
            wcCyc = cycNum;
            ueAtWc = int'(underflow_err);
            if (!busy) busyDrop++;
        end else if (underflow_err) begin
            ueStray++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        sclkEdges = 0; firstEdgeCyc = -1; lastEdgeCyc = -1; popsSeen = 0;
        wcCount = 0; wcCyc = -1; ueAtWc = 0; ueStray = 0; busyDrop = 0;
        busyCycles = 0; overPops = 0;
        mosiBits.delete();
    endtask

    // Runs one write command with stimQ preloaded into the FIFO and checks the result.
    task automatic applyStimulus(input logic [7:0] addr, input int n, input bit glitch,
                                 input bit holdHigh, input string tag);
        int depth, expPops, guard, limit, bitErr, startCyc;
        bit expUf;
        logic expBits[$];
        logic [7:0] b;
        depth   = stimQ.size();
        expPops = (depth < n) ? depth : n;
        expUf   = (depth < n);
        for (int i = RW - 1; i >= 0; i--) expBits.push_back(addr[i]);
        for (int k = 0; k < expPops; k++) begin
            b = stimQ[k];
            for (int i = RW - 1; i >= 0; i--) expBits.push_back(b[i]);
        end

        @(negedge clk);
        fifoQ = stimQ;
        fifo_empty = (fifoQ.size() == 0);
        clearMonitor();
        is_write = 1'b1;
        num_regs_to_write = 8'(n);
        start_write_register_addr = addr;
        new_command = 1'b1;
        startCyc = cycNum;
        @(negedge clk);
        if (!holdHigh) new_command = 1'b0;
        if (glitch) begin
            repeat (3) @(negedge clk);
            new_command = 1'b1;
            num_regs_to_write = ~num_regs_to_write;
            start_write_register_addr = ~addr;
            @(negedge clk);
            new_command = 1'b0;
        end
        limit = RW * (n + 1) + 50;
        guard = 0;
        while (wcCount == 0 && guard < limit) begin
            @(negedge clk);
            #2;
            guard++;
        end
        checkOutput({tag, " complete_seen"}, (wcCount > 0) ? 1 : 0, 1);
        repeat (20) @(negedge clk);
        #2;
        new_command = 1'b0;

        bitErr = 0;
        for (int i = 0; i < expBits.size() && i < mosiBits.size(); i++)
            if (mosiBits[i] !== expBits[i]) bitErr++;
        checkOutput({tag, " sclk_edges"}, sclkEdges, RW * (expPops + 1));
        checkOutput({tag, " mosi_len"}, mosiBits.size(), expBits.size());
        checkOutput({tag, " mosi_bit_errors"}, bitErr, 0);
        checkOutput({tag, " contiguous_sclk"}, lastEdgeCyc - firstEdgeCyc + 1, sclkEdges);
        checkOutput({tag, " first_bit_cycle"}, firstEdgeCyc, startCyc + 1);
        checkOutput({tag, " complete_cycle"}, wcCyc, lastEdgeCyc + 1);
        checkOutput({tag, " pops"}, popsSeen, expPops);
        checkOutput({tag, " over_pops"}, overPops, 0);
        checkOutput({tag, " complete_pulses"}, wcCount, 1);
        checkOutput({tag, " underflow_at_complete"}, ueAtWc, int'(expUf));
        checkOutput({tag, " stray_underflow"}, ueStray, 0);
        checkOutput({tag, " busy_drops"}, busyDrop, 0);
        checkOutput({tag, " busy_cycles"}, busyCycles, RW * (expPops + 1) + 1);
        checkOutput({tag, " busy_after"}, busy, 0);
        checkOutput({tag, " fifo_left"}, fifoQ.size(), depth - expPops);
        fifoQ.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic applyReject(input bit wr, input int n, input string tag);
        @(negedge clk);
        fifoQ = {8'h11, 8'h22, 8'h33, 8'h44};
        fifo_empty = 1'b0;
        clearMonitor();
        is_write = wr;
        num_regs_to_write = 8'(n);
        start_write_register_addr = 8'hE7;
        new_command = 1'b1;
        @(negedge clk);
        new_command = 1'b0;
        repeat (30) @(negedge clk);
        #2;
        checkOutput({tag, " sclk_edges"}, sclkEdges, 0);
        checkOutput({tag, " complete_pulses"}, wcCount + ueStray, 0);
        checkOutput({tag, " pops"}, popsSeen, 0);
        checkOutput({tag, " busy_cycles"}, busyCycles, 0);
        fifoQ.delete();
        fifo_empty = 1'b1;
        is_write = 1'b1;
    endtask

    task automatic resetMidTransfer();
        int startCyc;
        @(negedge clk);
        fifoQ = {8'h9C, 8'h3E};
        fifo_empty = 1'b0;
        clearMonitor();
        is_write = 1'b1;
        num_regs_to_write = 8'd2;
        start_write_register_addr = 8'hB6;
        new_command = 1'b1;
        startCyc = cycNum;
        @(negedge clk);
        new_command = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid at_addr_bit4", cycNum, startCyc + 4);
        rstn = 1'b0;
        #1;
        checkOutput("rst_mid sclk_forced_low", spi_clk, 0);
        @(negedge clk);
        #1;
        checkOutput("rst_mid outputs_cleared",
                    {26'd0, fifo_rd_en, serial_out, spi_clk, busy, write_complete, underflow_err}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        checkOutput("rst_mid no_complete", wcCount, 0);
        checkOutput("rst_mid sclk_edges", sclkEdges, 3);
        fifoQ.delete();
        fifo_empty = 1'b1;
    endtask

    initial begin
        int n, depth;
        logic [7:0] addr;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset outputs",
                    {26'd0, fifo_rd_en, serial_out, spi_clk, busy, write_complete, underflow_err}, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        stimQ = {8'hC3};
        applyStimulus(8'h5A, 1, 1'b0, 1'b0, "single");
        stimQ = {8'h01, 8'h80, 8'hFF};
        applyStimulus(8'h10, 3, 1'b0, 1'b0, "burst");
        stimQ = {8'hA5};
        applyStimulus(8'h3C, 3, 1'b0, 1'b0, "underflow");
        stimQ = {8'h00};
        stimQ.delete();
        applyStimulus(8'hF0, 2, 1'b0, 1'b0, "empty_fifo");
        stimQ = {8'h12, 8'h34, 8'h56};
        applyStimulus(8'h77, 3, 1'b1, 1'b0, "glitch");
        stimQ = {8'hDE, 8'hAD};
        applyStimulus(8'h81, 2, 1'b0, 1'b1, "held_high");

        applyReject(1'b0, 3, "not_write");
        applyReject(1'b1, 0, "zero_regs");

        resetMidTransfer();
        stimQ = {8'h4B, 8'hE1};
        applyStimulus(8'h2D, 2, 1'b0, 1'b0, "after_reset");

        for (int t = 0; t < 10; t++) begin
            n = $urandom_range(1, 12);
            depth = ($urandom_range(0, 1) == 1) ? n + $urandom_range(0, 2) : $urandom_range(0, n - 1);
            addr = 8'($urandom);
            stimQ.delete();
            for (int k = 0; k < depth; k++) stimQ.push_back(8'($urandom));
            applyStimulus(addr, n, 1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        stimQ.delete();
        for (int k = 0; k < 255; k++) stimQ.push_back(8'($urandom));
        applyStimulus(8'($urandom), 255, 1'b0, 1'b0, "max_len");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_write.md
Name: spi_write

Overview:
- SPI controller-side write engine, the write counterpart of the register-read path in the SPI driver.
- On a write command it shifts out a start register address, then `num_regs` data bytes. Data bytes are pulled one at a time from an upstream FIFO with 1-cycle read latency.
- Sits beside the read engine on the shared SCLK/MOSI lines; an external mux selects the active engine. Only the engine's own outputs are specified here.

Parameters:
- REG_WIDTH, 8, bits per address word and per data byte; shifted MSB first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rstn  input  1  reset, synchronous, active-low; forces `spi_clk` to 0 combinationally while low.
- new_command  input  1  command strobe; acted on at its rising edge.
- is_write  input  1  command accepted only when 1.
- num_regs_to_write  input  8  number of data bytes; latched at accept.
- start_write_register_addr  input  REG_WIDTH  first register address; latched at accept.
- fifo_rd_data  input  REG_WIDTH  FIFO output word; valid in the cycle after `fifo_rd_en`.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  one-cycle pop request.
- serial_out  output  1  MOSI.
- spi_clk  output  1  gated SCLK, equal to ~clk while enabled, else 0.
- busy  output  1  high in every state except IDLE.
- write_complete  output  1  one-cycle pulse at end of transfer.
- underflow_err  output  1  one-cycle pulse, coincident with `write_complete`, when the transfer was truncated.

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE; `fifo_rd_en`, `serial_out`, `write_complete`, `underflow_err`, `busy` = 0; SCLK enable=0; counters=0; `prev_new_command`=0.
- Reset mid-transfer: abort at the next posedge. No `write_complete` pulse.
- **Command detection**
  - Accept when `new_command` && !`prev_new_command` && `is_write` && state==IDLE.
  - Rising edges while busy, or with `is_write`=0, are ignored.
  - A command with `num_regs_to_write`=0 is ignored: stay IDLE, no pulses.
- **Bit timing**
  - `serial_out` updates on posedge clk.
  - SCLK rises at the clk negedge, so the peripheral samples mid-bit.
  - Exactly one SCLK pulse per bit.
- **States**
  - IDLE: wait for accept. The cycle after accept enters SEND_ADDRESS with bit REG_WIDTH-1 of the address on `serial_out` and SCLK enabled.
  - SEND_ADDRESS: REG_WIDTH bit-cycles, MSB first.
  - SEND_DATA: REG_WIDTH bit-cycles per byte, MSB first. Bytes are back-to-back with no SCLK gaps between the address and data or between bytes.
  - COMPLETE: SCLK disabled, `serial_out`=0, `write_complete`=1 for one cycle, then IDLE. `busy` drops in IDLE.
- **Prefetch**
  - Each byte's `fifo_rd_en` is high during the bit-cycle carrying bit index 1 (second-to-last bit) of the preceding word (address or previous data byte).
  - `fifo_rd_data` is captured at the end of the following cycle (bit 0) into the shift register for the next word.
  - Exactly N pops per transfer; never pop beyond N.
- **Underflow**
  - If `fifo_empty`=1 in the cycle a pop is due, do not pop.
  - Finish the current word, then go to COMPLETE with `underflow_err`=1 alongside `write_complete`.
  - Bytes already sent are not retracted.
- **Counting and latency**
  - Bit counter is at least 12 bits and counts total bits, REG_WIDTH*(N+1) max = 2048 for N=255.
  - Accept to first bit: 1 cycle.
  - Last bit to `write_complete`: 1 cycle.
- **Simultaneous events**
  - A new rising edge in the same cycle as COMPLETE is ignored. `prev_new_command` still tracks, so it is not re-detected later.

Decomposition:
- Package `spi_pkg`: `spi_wr_state_t` enum {IDLE, SEND_ADDRESS, SEND_DATA, COMPLETE}; localparam `SPI_CNT_W`=12.
- Sub-module `spi_piso_shift`: REG_WIDTH parallel-load, MSB-first shift register with load/shift enables.
- Top level holds the FSM, counters, FIFO handshake and SCLK gating.

Test Plan:
- **Single byte:** addr=0x5A, N=1, FIFO holds 0xC3, `is_write`=1.
  - 16 SCLK rising edges; MOSI = 0101_1010_1100_0011.
  - One `fifo_rd_en` pulse, during address bit 1.
  - `write_complete` 1 cycle after the last bit; `underflow_err`=0.
- **Burst:** addr=0x10, N=3, FIFO = 0x01, 0x80, 0xFF.
  - 32 contiguous SCLK edges, correct bit stream.
  - Exactly 3 `fifo_rd_en` pulses; `busy` high throughout.
- **Underflow:** N=3, FIFO holds 1 byte.
  - 16 SCLK edges; second pop suppressed.
  - `write_complete` and `underflow_err` both pulse in the same cycle.
- **Rejected commands:**
  - `is_write`=0: no SCLK.
  - N=0: no SCLK, no pulses.
  - Second rising edge mid-transfer: ignored, transfer unchanged.
  - `new_command` held high after completion: no retrigger.
- **Reset mid-transfer:** `rstn`=0 at address bit 4.
  - `spi_clk`=0 immediately.
  - All outputs 0 at the next posedge; no `write_complete`.
  - A new command after release runs normally.
- **Max length:** N=255.
  - 2048 SCLK edges, 255 pops, single `write_complete`; no counter wrap.
